// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, read-side state encoding and
// the Gray/binary pointer conversions used by both clock domains.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 16;
    localparam int unsigned FIFO_PTR_WIDTH  = 8;

    typedef enum logic {
        RD_EMPTY = 1'b0,
        RD_VALID = 1'b1
    } rd_state_e;

    // Width-agnostic: callers zero-extend to 32 bits and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done with doubling shifts.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: FWFT head word straight off the RAM
// read port, Gray read pointer back to the write domain, level/status flags.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = FIFO_DATA_WIDTH,
    parameter int unsigned PTR_WIDTH       = FIFO_PTR_WIDTH,
    parameter int unsigned ALMOST_EMPTY_TH = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [PTR_WIDTH:0]    w2r_w_ptr_gray,
    input  logic                  rd_ready,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_rd_en,
    output logic [PTR_WIDTH-1:0]  ram_rd_addr,
    output logic [PTR_WIDTH:0]    rd_ptr_gray,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    rd_level,
    output logic                  underflow
);

    localparam int unsigned PW1 = PTR_WIDTH + 1;

    rd_state_e            state_q;
    logic [PTR_WIDTH:0]   rd_ptr_bin_q;
    logic [PTR_WIDTH:0]   rd_ptr_bin_d;
    logic [PTR_WIDTH:0]   rd_ptr_gray_q;
    logic                 underflow_q;
    logic [PTR_WIDTH:0]   wbin;
    logic [PTR_WIDTH:0]   fill;
    logic                 fetch;

    // The extra wrap bit lets fill reach 2^PTR_WIDTH when the RAM is full.
    always_comb begin
        wbin         = PW1'(gray2bin(32'(w2r_w_ptr_gray)));
        fill         = wbin - rd_ptr_bin_q;
        fetch        = rd_rst_n && (fill != '0) && ((state_q == RD_EMPTY) || rd_ready);
        rd_ptr_bin_d = rd_ptr_bin_q + PW1'(fetch);
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q       <= RD_EMPTY;
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= PW1'(bin2gray(32'(rd_ptr_bin_q)));
            underflow_q   <= rd_ready && (state_q == RD_EMPTY);
            case (state_q)
                RD_EMPTY: if (fetch) state_q <= RD_VALID;
                RD_VALID: if (rd_ready && !fetch) state_q <= RD_EMPTY;
                default:  state_q <= RD_EMPTY;
            endcase
        end
    end

    assign ram_rd_en    = fetch;
    assign ram_rd_addr  = rd_ptr_bin_q[PTR_WIDTH-1:0];
    assign rd_ptr_gray  = rd_ptr_gray_q;
    assign dout         = ram_rdata;
    assign dout_valid   = (state_q == RD_VALID);
    assign empty        = !dout_valid;
    // Forced to zero in reset so a stale write pointer cannot show a level.
    assign rd_level     = rd_rst_n ? (fill + PW1'(dout_valid)) : '0;
    assign almost_empty = (32'(rd_level) <= ALMOST_EMPTY_TH);
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: bench acts as writer and RAM; expectations come from
// counting words written and consumed.
module tb_fifo_rd_ctrl;

    localparam int DW    = 16;
    localparam int PW    = 8;
    localparam int PW1   = PW + 1;
    localparam int TH    = 4;
    localparam int DEPTH = 1 << PW;
    localparam int SPW   = 3;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic          rd_rst_n;
    logic [PW:0]   w2r_w_ptr_gray;
    logic          rd_ready;
    logic [DW-1:0] ram_rdata;
    logic          ram_rd_en;
    logic [PW-1:0] ram_rd_addr;
    logic [PW:0]   rd_ptr_gray;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          empty;
    logic          almost_empty;
    logic [PW:0]   rd_level;
    logic          underflow;

    logic [SPW:0]   s_w_gray;
    logic           s_ready;
    logic [DW-1:0]  s_rdata;
    logic           s_rd_en;
    logic [SPW-1:0] s_rd_addr;
    logic [SPW:0]   s_rd_ptr_gray;
    logic [DW-1:0]  s_dout;
    logic           s_dout_valid;
    logic           s_empty;
    logic           s_almost_empty;
    logic [SPW:0]   s_rd_level;
    logic           s_underflow;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .ALMOST_EMPTY_TH(TH)) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .w2r_w_ptr_gray(w2r_w_ptr_gray),
        .rd_ready(rd_ready), .ram_rdata(ram_rdata), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .rd_ptr_gray(rd_ptr_gray), .dout(dout),
        .dout_valid(dout_valid), .empty(empty), .almost_empty(almost_empty),
        .rd_level(rd_level), .underflow(underflow)
    );

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(SPW), .ALMOST_EMPTY_TH(TH)) dut_small (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .w2r_w_ptr_gray(s_w_gray),
        .rd_ready(s_ready), .ram_rdata(s_rdata), .ram_rd_en(s_rd_en),
        .ram_rd_addr(s_rd_addr), .rd_ptr_gray(s_rd_ptr_gray), .dout(s_dout),
        .dout_valid(s_dout_valid), .empty(s_empty), .almost_empty(s_almost_empty),
        .rd_level(s_rd_level), .underflow(s_underflow)
    );

    assign s_rdata = 16'h5a5a;

    // RAM model: registered read, holds its output when not strobed.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge rd_clk) if (ram_rd_en) ram_rdata <= mem[ram_rd_addr];

    int checks = 0;
    int errors = 0;

    // Reference model state: words made visible, words consumed, head status.
    int            vis;
    int            cons;
    int            ptr_prev;
    logic          exp_valid;
    logic          exp_uf;
    logic [DW-1:0] exp_q[$];

    int fetch_log[$];
    int valid_cycles;
    int uf_cnt;
    always @(posedge rd_clk) if (rd_rst_n && ram_rd_en) fetch_log.push_back(int'(ram_rd_addr));
    always @(negedge rd_clk) begin
        if (dout_valid) valid_cycles++;
        if (underflow) uf_cnt++;
    end

    function automatic logic [PW:0] g9(input int b);
        logic [PW:0] x;
        x = b[PW:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic [SPW:0] g4(input int b);
        logic [SPW:0] x;
        x = b[SPW:0];
        return x ^ (x >> 1);
    endfunction

    task automatic model_clear();
        vis = 0; cons = 0; ptr_prev = 0;
        exp_valid = 1'b0; exp_uf = 1'b0;
        exp_q.delete();
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[vis % DEPTH] = DW'($urandom);
            exp_q.push_back(mem[vis % DEPTH]);
            vis++;
        end
        w2r_w_ptr_gray = g9(vis);
    endtask

    task automatic do_reset();
        rd_rst_n = 1'b0;
        w2r_w_ptr_gray = '0;
        rd_ready = 1'b0;
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
        model_clear();
    endtask

    // One clock: compare every output against the model, then advance it.
    task automatic tick();
        int          ptr_now;
        int          ptr_next;
        logic [PW:0] e_lvl;
        logic        exp_en;
        @(negedge rd_clk);
        ptr_now = cons + int'(exp_valid);
        e_lvl = PW1'(vis - cons);
        checks += 6;
        if (dout_valid !== exp_valid) begin errors++; $display("FAIL dout_valid got %0b exp %0b t=%0t", dout_valid, exp_valid, $time); end
        if (empty !== !exp_valid) begin errors++; $display("FAIL empty got %0b exp %0b t=%0t", empty, !exp_valid, $time); end
        if (rd_level !== e_lvl) begin errors++; $display("FAIL rd_level got %0d exp %0d t=%0t", rd_level, e_lvl, $time); end
        if (almost_empty !== ((vis - cons) <= TH)) begin errors++; $display("FAIL almost_empty got %0b exp %0b t=%0t", almost_empty, ((vis - cons) <= TH), $time); end
        if (underflow !== exp_uf) begin errors++; $display("FAIL underflow got %0b exp %0b t=%0t", underflow, exp_uf, $time); end
        if (rd_ptr_gray !== g9(ptr_prev)) begin errors++; $display("FAIL rd_ptr_gray got %h exp %h t=%0t", rd_ptr_gray, g9(ptr_prev), $time); end
        if (exp_valid) begin
            checks++;
            if (dout !== exp_q[0]) begin errors++; $display("FAIL dout got %h exp %h t=%0t", dout, exp_q[0], $time); end
        end
        exp_uf = rd_ready && !exp_valid;
        if (exp_valid && rd_ready) begin
            cons++;
            void'(exp_q.pop_front());
        end
        exp_valid = (vis - cons) > 0;
        ptr_next = cons + int'(exp_valid);
        exp_en = (ptr_next != ptr_now);
        checks++;
        if (ram_rd_en !== exp_en) begin errors++; $display("FAIL ram_rd_en got %0b exp %0b t=%0t", ram_rd_en, exp_en, $time); end
        if (exp_en) begin
            checks++;
            if (int'(ram_rd_addr) !== ptr_now % DEPTH) begin errors++; $display("FAIL ram_rd_addr got %0d exp %0d t=%0t", ram_rd_addr, ptr_now % DEPTH, $time); end
        end
        ptr_prev = ptr_now;
        @(posedge rd_clk);
        #1;
    endtask

    task automatic test_reset();
        rd_rst_n = 1'b0;
        w2r_w_ptr_gray = '0;
        rd_ready = 1'b0;
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        checks += 5;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
        if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %0b exp 1", almost_empty); end
        if (rd_level !== '0) begin errors++; $display("FAIL reset_rd_level got %0d exp 0", rd_level); end
        if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_ram_rd_en got %0b exp 0", ram_rd_en); end
        if (rd_ptr_gray !== '0) begin errors++; $display("FAIL reset_rd_ptr_gray got %h exp 0", rd_ptr_gray); end
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
        model_clear();
        repeat (2) tick();
    endtask

    task automatic test_single_step();
        do_reset();
        fetch_log.delete();
        write_words(3);
        repeat (4) tick();
        checks += 5;
        if (dout_valid !== 1'b1) begin errors++; $display("FAIL step_dout_valid got %0b exp 1", dout_valid); end
        if (rd_level !== PW1'(3)) begin errors++; $display("FAIL step_rd_level got %0d exp 3", rd_level); end
        if (almost_empty !== 1'b1) begin errors++; $display("FAIL step_almost_empty got %0b exp 1", almost_empty); end
        if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL step_ram_rd_en got %0b exp 0", ram_rd_en); end
        if (fetch_log.size() != 1 || fetch_log[0] != 0) begin errors++; $display("FAIL step_fetches got %0d exp 1 at addr 0", fetch_log.size()); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_log.delete();
        write_words(10);
        rd_ready = 1'b1;
        valid_cycles = 0;
        repeat (12) tick();
        checks += 4;
        if (valid_cycles != 10) begin errors++; $display("FAIL b2b_valid_cycles got %0d exp 10", valid_cycles); end
        if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %0b exp 1", empty); end
        if (rd_ptr_gray !== g9(10)) begin errors++; $display("FAIL b2b_rd_ptr_gray got %h exp %h", rd_ptr_gray, g9(10)); end
        if (fetch_log.size() != 10) begin errors++; $display("FAIL b2b_fetch_count got %0d exp 10", fetch_log.size()); end
        for (int i = 0; i < fetch_log.size(); i++) begin
            checks++;
            if (fetch_log[i] != i) begin errors++; $display("FAIL b2b_fetch_addr got %0d exp %0d", fetch_log[i], i); end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_underflow();
        do_reset();
        uf_cnt = 0;
        rd_ready = 1'b1;
        repeat (5) tick();
        rd_ready = 1'b0;
        repeat (2) tick();
        checks += 2;
        if (uf_cnt != 5) begin errors++; $display("FAIL underflow_pulses got %0d exp 5", uf_cnt); end
        if (rd_ptr_gray !== '0) begin errors++; $display("FAIL underflow_ptr got %h exp 0", rd_ptr_gray); end
    endtask

    task automatic test_random();
        int pct;
        int room;
        int n;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            case ((c / 500) % 4)
                0: pct = 10;
                1: pct = 90;
                2: pct = 50;
                default: pct = 100;
            endcase
            room = DEPTH - (vis - (cons + int'(exp_valid)));
            n = $urandom_range(0, 3);
            if (n > room) n = room;
            write_words(n);
            rd_ready = ($urandom_range(0, 99) < pct);
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_words(6);
        repeat (2) tick();
        rd_rst_n = 1'b0;
        #1;
        checks += 6;
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_dout_valid got %0b exp 0", dout_valid); end
        if (rd_ptr_gray !== '0) begin errors++; $display("FAIL mid_rst_rd_ptr_gray got %h exp 0", rd_ptr_gray); end
        if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_ram_rd_en got %0b exp 0", ram_rd_en); end
        if (rd_level !== '0) begin errors++; $display("FAIL mid_rst_rd_level got %0d exp 0", rd_level); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %0b exp 1", empty); end
        if (almost_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_almost_empty got %0b exp 1", almost_empty); end
        w2r_w_ptr_gray = '0;
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
        model_clear();
        repeat (2) tick();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_after_empty got %0b exp 1", empty); end
    endtask

    // Three full-RAM rounds on the 3-bit instance; the second crosses 15 -> 0.
    task automatic test_wrap_small();
        int p0;
        int e_lvl;
        s_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            p0 = 8 * r;
            s_w_gray = g4(p0 + 8);
            for (int k = 0; k < 10; k++) begin
                @(negedge rd_clk);
                e_lvl = (k == 0) ? 8 : ((k <= 8) ? 9 - k : 0);
                checks += 2;
                if (s_rd_level !== (SPW+1)'(e_lvl)) begin errors++; $display("FAIL wrap_rd_level r=%0d k=%0d got %0d exp %0d", r, k, s_rd_level, e_lvl); end
                if (s_rd_ptr_gray !== g4((k == 0) ? p0 : p0 + k - 1)) begin
                    errors++;
                    $display("FAIL wrap_rd_ptr_gray r=%0d k=%0d got %h exp %h", r, k, s_rd_ptr_gray, g4((k == 0) ? p0 : p0 + k - 1));
                end
                @(posedge rd_clk);
                #1;
            end
            checks++;
            if (s_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty r=%0d got %0b exp 1", r, s_empty); end
        end
        s_ready = 1'b0;
    endtask

    initial begin
        rd_rst_n = 1'b0;
        w2r_w_ptr_gray = '0;
        rd_ready = 1'b0;
        s_w_gray = '0;
        s_ready = 1'b0;
        model_clear();
        test_reset();
        test_single_step();
        test_back_to_back();
        test_underflow();
        test_random();
        test_reset_mid();
        test_wrap_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
